// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B subtractor with start/done handshake
//
// Purpose:
//   Loads a and b in parallel on an accepted start. Consumes them one bit
//   per clock, LSB first, through a full-subtractor cell and a registered
//   borrow. Presents the parallel difference and the final borrow with a
//   one-cycle done pulse.
//
// Optional feature:
//   SUB_SAT_EN - when defined, an underflowing result (final borrow = 1)
//                is floored to zero. bout still reports the underflow.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; sampled only in IDLE
//   a      in   WIDTH  minuend, captured on the accepted start
//   b      in   WIDTH  subtrahend, captured on the accepted start
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse when diff/bout are updated
//   diff   out  WIDTH  (a-b) mod 2^WIDTH (floored to 0 on underflow with SUB_SAT_EN)
//   bout   out  1      final borrow, 1 iff a < b (unsigned)

// Full-subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bout_q,   bout_d;

  logic cell_d;
  logic cell_bout;

  // The cell always looks at the current LSBs; its outputs are only
  // consumed while in RUN.
  full_subtractor_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
          busy_d   = 1'b1;
        end
      end

      S_RUN: begin
        // Result bits enter at the MSB so that after WIDTH shifts the
        // first (LSB) difference bit has arrived at bit 0.
        res_d    = {cell_d, res_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = cell_bout;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_DONE: begin
`ifdef SUB_SAT_EN
        diff_d = borrow_q ? '0 : res_q;
`else
        diff_d = res_q;
`endif
        bout_d  = borrow_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer subtraction.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb);
    int dv;
    logic [W-1:0] d;
    logic bo;
    dv = int'(ra) - int'(rb);
    bo = (dv < 0);
    d  = bo ? W'(dv + (1 << W)) : W'(dv);
`ifdef SUB_SAT_EN
    if (bo) d = '0;
`endif
    return {bo, d};
  endfunction

  // Called just after a rising edge with the DUT idle. Returns the result,
  // the number of busy cycles, the done latency (edges after accept) and
  // diff as seen right after the accepting edge.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       output logic [W-1:0] d, output logic bo,
                       output int nbusy, output int lat, output logic [W-1:0] d_mid);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nbusy = 0;
    lat = -1;
    d_mid = diff;
    for (int i = 0; i < 30; i++) begin
      if (busy) nbusy++;
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    d = diff;
    bo = bout;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] d, d_mid, prev_d;
    logic         bo;
    logic [W:0]   r;
    int           nbusy, lat, ndone, n;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
`ifdef SUB_SAT_EN
    vecs[1] = '{8'h03, 8'h05, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'h00, 1'b1};
    vecs[7] = '{8'h00, 8'hFF, 8'h00, 1'b1};
`else
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[7] = '{8'h00, 8'hFF, 8'h01, 1'b1};
`endif
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0};

    // Reset with start asserted: must be ignored.
    rst = 1'b1;
    start = 1'b1;
    a = 8'h55;
    b = 8'h11;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 0);

    // Directed vectors.
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, d, bo, nbusy, lat, d_mid);
      check($sformatf("vec%0d_diff", i), d, vecs[i].d);
      check($sformatf("vec%0d_bout", i), bo, vecs[i].bo);
      check($sformatf("vec%0d_busy_cycles", i), nbusy, W);
      check($sformatf("vec%0d_latency", i), lat, W + 1);
    end

    // Back-to-back with start held high.
    a = 8'h00;
    b = 8'h01;
    start = 1'b1;
    n = -1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
    r = ref_sub(8'h00, 8'h01);
    check("b2b_first_seen", (n >= 0), 1);
    check("b2b_first_diff", diff, r[W-1:0]);
    check("b2b_first_bout", bout, r[W]);
    a = 8'hFF;
    b = 8'hFF;
    n = -1;
    for (int i = 1; i < 30; i++) begin
      @(posedge clk); #1;
      if (i == 1) check("b2b_done_pulse_width", done, 0);
      if (done) begin
        n = i;
        break;
      end
    end
    start = 1'b0;
    check("b2b_gap", n, W + 2);
    check("b2b_second_diff", diff, 8'h00);
    check("b2b_second_bout", bout, 0);
    @(posedge clk); #1;

    // Start during RUN is ignored.
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk); #1;
    a = 8'h20;
    b = 8'h20;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    d = '0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        ndone++;
        d = diff;
      end
      @(posedge clk); #1;
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_diff", d, 8'h0F);

    // Reset in the middle of RUN.
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrun_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_busy", busy, 0);
    check("midrun_done", done, 0);
    check("midrun_diff", diff, 0);
    check("midrun_bout", bout, 0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) ndone++;
      @(posedge clk); #1;
    end
    check("midrun_no_activity", ndone, 0);
    do_op(8'd9, 8'd4, d, bo, nbusy, lat, d_mid);
    check("after_rst_diff", d, 8'h05);
    check("after_rst_bout", bo, 0);

    // Randomized against the reference.
    prev_d = d;
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) rb = ra;
      r = ref_sub(ra, rb);
      do_op(ra, rb, d, bo, nbusy, lat, d_mid);
      check($sformatf("rnd%0d_hold_diff", i), d_mid, prev_d);
      check($sformatf("rnd%0d_diff", i), d, r[W-1:0]);
      check($sformatf("rnd%0d_bout", i), bo, r[W]);
      check($sformatf("rnd%0d_latency", i), lat, W + 1);
      prev_d = r[W-1:0];
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
